register_file_multiport: RTL and testbench

- Parametrised successor to the single-write CPU register file.
- Configurable data width, depth, read-port count and write-port count.
- Adds write-to-read bypass and a per-register pending-write scoreboard for multicycle/out-of-order writeback.
- Sits between decode/issue (read, reserve) and the writeback stage(s) of the Mini-MIPS datapath.

---
 rtl/register_file_multiport_pkg.sv | 14 +
 rtl/register_file_multiport_if.sv | 32 +++
 rtl/register_file_multiport_scoreboard.sv | 76 +++++++
 rtl/register_file_multiport.sv | 90 +++++++++
 tb/tb_register_file_multiport.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/register_file_multiport_pkg.sv
// Shared constants and slice helper for the multi-port register file.
// Imported by the interface, the scoreboard and the top module.
package register_file_multiport_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;
  localparam int REGISTER_RZERO     = 0;

  // Low bit of port 'port' inside a packed bus of 'width'-bit fields.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/register_file_multiport_if.sv
// Bus bundle between issue/writeback logic (master) and the register file (slave).
// Packed multi-port fields: port p lives at [p*W +: W].
interface register_file_multiport_if
  import register_file_multiport_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2
);

  logic [READ_PORTS*ADDR_WIDTH-1:0]  read_reg;
  logic [READ_PORTS*DATA_WIDTH-1:0]  read_data;
  logic [READ_PORTS-1:0]             read_busy;
  logic [WRITE_PORTS-1:0]            write_enable;
  logic [WRITE_PORTS*ADDR_WIDTH-1:0] write_reg;
  logic [WRITE_PORTS*DATA_WIDTH-1:0] write_data;
  logic                              reserve_enable;
  logic [ADDR_WIDTH-1:0]             reserve_reg;
  logic [ADDR_WIDTH:0]               busy_count;

  modport master (
    output read_reg, write_enable, write_reg, write_data, reserve_enable, reserve_reg,
    input  read_data, read_busy, busy_count
  );

  modport slave (
    input  read_reg, write_enable, write_reg, write_data, reserve_enable, reserve_reg,
    output read_data, read_busy, busy_count
  );

endinterface

// File: rtl/register_file_multiport_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a registered busy count.
// A reserve in the same cycle as a retiring write to that register keeps it busy.
module register_file_multiport_scoreboard
  import register_file_multiport_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2,
  parameter int ZERO_REG    = 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [WRITE_PORTS-1:0]          i_write_enable,
  input  logic [WRITE_PORTS*ADDR_WIDTH-1:0] i_write_reg,
  input  logic                            i_reserve_enable,
  input  logic [ADDR_WIDTH-1:0]           i_reserve_reg,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] i_read_reg,
  output logic [READ_PORTS-1:0]           o_read_busy,
  output logic [ADDR_WIDTH:0]             o_busy_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DEPTH-1:0]    r_busy;
  logic [DEPTH-1:0]    w_busy_next;
  logic [ADDR_WIDTH:0] r_busy_count;
  logic [ADDR_WIDTH:0] w_busy_count_next;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_bit
      if (ZERO_REG != 0 && gi == REGISTER_RZERO) begin : g_zero
        assign w_busy_next[gi] = 1'b0;
      end else begin : g_normal
        logic w_clear;
        logic w_set;
        always_comb begin
          w_clear = 1'b0;
          for (int w = 0; w < WRITE_PORTS; w++) begin
            if (i_write_enable[w] &&
                i_write_reg[slice_lo(w, ADDR_WIDTH) +: ADDR_WIDTH] == ADDR_WIDTH'(gi))
              w_clear = 1'b1;
          end
          w_set = i_reserve_enable && (i_reserve_reg == ADDR_WIDTH'(gi));
        end
        // Set dominates clear: the newly issued producer supersedes the retiring one.
        assign w_busy_next[gi] = w_set | (r_busy[gi] & ~w_clear);
      end
    end
  endgenerate

  always_comb begin
    w_busy_count_next = '0;
    for (int i = 0; i < DEPTH; i++)
      w_busy_count_next = w_busy_count_next + {{ADDR_WIDTH{1'b0}}, w_busy_next[i]};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_busy       <= '0;
      r_busy_count <= '0;
    end else begin
      r_busy       <= w_busy_next;
      r_busy_count <= w_busy_count_next;
    end
  end

  generate
    for (gi = 0; gi < READ_PORTS; gi++) begin : g_rd_busy
      assign o_read_busy[gi] = r_busy[i_read_reg[slice_lo(gi, ADDR_WIDTH) +: ADDR_WIDTH]];
    end
  endgenerate

  assign o_busy_count = r_busy_count;

endmodule

// File: rtl/register_file_multiport.sv
// Multi-port register file with write-to-read bypass, hardwired zero register
// and a pending-write scoreboard for out-of-order writeback.
module register_file_multiport
  import register_file_multiport_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2,
  parameter int ZERO_REG    = 1,
  parameter int BYPASS      = 1
) (
  input logic                      clock,
  input logic                      reset,
  register_file_multiport_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [WRITE_PORTS-1:0] w_write_valid;
  logic [ADDR_WIDTH-1:0]  w_write_addr [WRITE_PORTS];
  logic [DATA_WIDTH-1:0]  w_write_data [WRITE_PORTS];

  genvar gi;
  generate
    for (gi = 0; gi < WRITE_PORTS; gi++) begin : g_wr
      assign w_write_addr[gi] = bus.write_reg[slice_lo(gi, ADDR_WIDTH) +: ADDR_WIDTH];
      assign w_write_data[gi] = bus.write_data[slice_lo(gi, DATA_WIDTH) +: DATA_WIDTH];
      // Writes to the zero register are dropped before they reach the array or bypass.
      assign w_write_valid[gi] = bus.write_enable[gi] &&
          !(ZERO_REG != 0 && w_write_addr[gi] == ADDR_WIDTH'(REGISTER_RZERO));
    end
  endgenerate

  // Ports are applied in ascending order so the highest-index port wins a conflict.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else begin
      for (int w = 0; w < WRITE_PORTS; w++) begin
        if (w_write_valid[w])
          r_mem[w_write_addr[w]] <= w_write_data[w];
      end
    end
  end

  generate
    for (gi = 0; gi < READ_PORTS; gi++) begin : g_rd
      logic [ADDR_WIDTH-1:0] w_addr;
      logic [DATA_WIDTH-1:0] w_data;

      assign w_addr = bus.read_reg[slice_lo(gi, ADDR_WIDTH) +: ADDR_WIDTH];

      always_comb begin
        w_data = r_mem[w_addr];
        if (BYPASS != 0) begin
          for (int w = 0; w < WRITE_PORTS; w++) begin
            if (w_write_valid[w] && w_write_addr[w] == w_addr)
              w_data = w_write_data[w];
          end
        end
        if (ZERO_REG != 0 && w_addr == ADDR_WIDTH'(REGISTER_RZERO))
          w_data = '0;
      end

      assign bus.read_data[slice_lo(gi, DATA_WIDTH) +: DATA_WIDTH] = w_data;
    end
  endgenerate

  register_file_multiport_scoreboard #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .READ_PORTS  (READ_PORTS),
    .WRITE_PORTS (WRITE_PORTS),
    .ZERO_REG    (ZERO_REG)
  ) u_scoreboard (
    .clock            (clock),
    .reset            (reset),
    .i_write_enable   (bus.write_enable),
    .i_write_reg      (bus.write_reg),
    .i_reserve_enable (bus.reserve_enable),
    .i_reserve_reg    (bus.reserve_reg),
    .i_read_reg       (bus.read_reg),
    .o_read_busy      (bus.read_busy),
    .o_busy_count     (bus.busy_count)
  );

endmodule

// File: tb/tb_register_file_multiport.sv
// Directed bench: two instances (bypass on / bypass off) driven by the same stimulus.
module tb_register_file_multiport;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [9:0]  tb_read_reg    = '0;
  logic [1:0]  tb_we          = '0;
  logic [9:0]  tb_wreg        = '0;
  logic [63:0] tb_wdata       = '0;
  logic        tb_reserve_en  = 1'b0;
  logic [4:0]  tb_reserve_reg = '0;

  register_file_multiport_if if_a ();
  register_file_multiport_if if_b ();

  assign if_a.read_reg = tb_read_reg;       assign if_b.read_reg = tb_read_reg;
  assign if_a.write_enable = tb_we;         assign if_b.write_enable = tb_we;
  assign if_a.write_reg = tb_wreg;          assign if_b.write_reg = tb_wreg;
  assign if_a.write_data = tb_wdata;        assign if_b.write_data = tb_wdata;
  assign if_a.reserve_enable = tb_reserve_en;  assign if_b.reserve_enable = tb_reserve_en;
  assign if_a.reserve_reg = tb_reserve_reg;    assign if_b.reserve_reg = tb_reserve_reg;

  register_file_multiport #(.BYPASS(1)) dut_a (.clock(clk), .reset(rst), .bus(if_a.slave));
  register_file_multiport #(.BYPASS(0)) dut_b (.clock(clk), .reset(rst), .bus(if_b.slave));

  logic [31:0] a_rd0, a_rd1, b_rd0, b_rd1;
  assign a_rd0 = if_a.read_data[31:0];
  assign a_rd1 = if_a.read_data[63:32];
  assign b_rd0 = if_b.read_data[31:0];
  assign b_rd1 = if_b.read_data[63:32];

  int checks = 0;
  int errors = 0;

  task automatic idle();
    tb_we = '0;
    tb_reserve_en = 1'b0;
  endtask

  task automatic test_reset();
    tb_read_reg = {5'd5, 5'd1};
    #2;
    checks++; if (a_rd0 !== 32'h0) begin errors++; $display("FAIL reset_rd0: got %h expected %h", a_rd0, 32'h0); end
    checks++; if (a_rd1 !== 32'h0) begin errors++; $display("FAIL reset_rd1: got %h expected %h", a_rd1, 32'h0); end
    checks++; if (if_a.busy_count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", if_a.busy_count); end
    checks++; if (if_a.read_busy !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b expected 00", if_a.read_busy); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_write_bypass();
    @(negedge clk);
    tb_we = 2'b01; tb_wreg = {5'd0, 5'd3}; tb_wdata = {32'h0, 32'h12345678};
    tb_read_reg = {5'd3, 5'd0};
    #1;
    checks++; if (a_rd1 !== 32'h12345678) begin errors++; $display("FAIL bypass_same_cycle: got %h expected %h", a_rd1, 32'h12345678); end
    checks++; if (b_rd1 !== 32'h0) begin errors++; $display("FAIL nobypass_same_cycle: got %h expected %h", b_rd1, 32'h0); end
    @(posedge clk); #1; idle(); #1;
    checks++; if (a_rd1 !== 32'h12345678) begin errors++; $display("FAIL bypass_next_cycle: got %h expected %h", a_rd1, 32'h12345678); end
    checks++; if (b_rd1 !== 32'h12345678) begin errors++; $display("FAIL nobypass_next_cycle: got %h expected %h", b_rd1, 32'h12345678); end
  endtask

  task automatic test_conflict();
    @(negedge clk);
    tb_we = 2'b11; tb_wreg = {5'd7, 5'd7}; tb_wdata = {32'h2, 32'h1};
    tb_read_reg = {5'd3, 5'd7};
    #1;
    checks++; if (a_rd0 !== 32'h2) begin errors++; $display("FAIL conflict_bypass: got %h expected %h", a_rd0, 32'h2); end
    checks++; if (b_rd0 !== 32'h0) begin errors++; $display("FAIL conflict_nobypass: got %h expected %h", b_rd0, 32'h0); end
    @(posedge clk); #1; idle(); #1;
    checks++; if (a_rd0 !== 32'h2) begin errors++; $display("FAIL conflict_array_a: got %h expected %h", a_rd0, 32'h2); end
    checks++; if (b_rd0 !== 32'h2) begin errors++; $display("FAIL conflict_array_b: got %h expected %h", b_rd0, 32'h2); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    tb_we = 2'b01; tb_wreg = {5'd0, 5'd0}; tb_wdata = {32'h0, 32'hFFFFFFFF};
    tb_reserve_en = 1'b1; tb_reserve_reg = 5'd0;
    tb_read_reg = {5'd0, 5'd0};
    #1;
    checks++; if (a_rd0 !== 32'h0) begin errors++; $display("FAIL zero_bypass: got %h expected %h", a_rd0, 32'h0); end
    @(posedge clk); #1; idle(); #1;
    checks++; if (a_rd1 !== 32'h0) begin errors++; $display("FAIL zero_read: got %h expected %h", a_rd1, 32'h0); end
    checks++; if (if_a.read_busy !== 2'b00) begin errors++; $display("FAIL zero_busy: got %b expected 00", if_a.read_busy); end
    checks++; if (if_a.busy_count !== 6'd0) begin errors++; $display("FAIL zero_count: got %0d expected 0", if_a.busy_count); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    tb_reserve_en = 1'b1; tb_reserve_reg = 5'd9;
    tb_read_reg = {5'd0, 5'd9};
    @(posedge clk); #1; idle(); #1;
    checks++; if (if_a.read_busy[0] !== 1'b1) begin errors++; $display("FAIL sb_busy_set: got %b expected 1", if_a.read_busy[0]); end
    checks++; if (if_a.busy_count !== 6'd1) begin errors++; $display("FAIL sb_count_set: got %0d expected 1", if_a.busy_count); end
    @(negedge clk);
    tb_we = 2'b01; tb_wreg = {5'd0, 5'd9}; tb_wdata = {32'h0, 32'hAA};
    #1;
    checks++; if (if_a.read_busy[0] !== 1'b1) begin errors++; $display("FAIL sb_busy_during_write: got %b expected 1", if_a.read_busy[0]); end
    checks++; if (a_rd0 !== 32'hAA) begin errors++; $display("FAIL sb_bypass: got %h expected %h", a_rd0, 32'hAA); end
    @(posedge clk); #1; idle(); #1;
    checks++; if (if_a.read_busy[0] !== 1'b0) begin errors++; $display("FAIL sb_busy_clear: got %b expected 0", if_a.read_busy[0]); end
    checks++; if (if_a.busy_count !== 6'd0) begin errors++; $display("FAIL sb_count_clear: got %0d expected 0", if_a.busy_count); end
    checks++; if (a_rd0 !== 32'hAA) begin errors++; $display("FAIL sb_data: got %h expected %h", a_rd0, 32'hAA); end
  endtask

  task automatic test_collision();
    @(negedge clk);
    tb_reserve_en = 1'b1; tb_reserve_reg = 5'd4;
    tb_read_reg = {5'd10, 5'd4};
    @(posedge clk); #1; idle(); #1;
    checks++; if (if_a.busy_count !== 6'd1) begin errors++; $display("FAIL col_pre_count: got %0d expected 1", if_a.busy_count); end
    @(negedge clk);
    tb_reserve_en = 1'b1; tb_reserve_reg = 5'd4;
    tb_we = 2'b01; tb_wreg = {5'd0, 5'd4}; tb_wdata = {32'h0, 32'h55};
    @(posedge clk); #1; idle(); #1;
    checks++; if (if_a.read_busy[0] !== 1'b1) begin errors++; $display("FAIL col_busy: got %b expected 1", if_a.read_busy[0]); end
    checks++; if (a_rd0 !== 32'h55) begin errors++; $display("FAIL col_data: got %h expected %h", a_rd0, 32'h55); end
    checks++; if (if_a.busy_count !== 6'd1) begin errors++; $display("FAIL col_count: got %0d expected 1", if_a.busy_count); end
    // Re-reserve an already busy register, then add a second one.
    @(negedge clk);
    tb_reserve_en = 1'b1; tb_reserve_reg = 5'd4;
    @(posedge clk); #1; idle(); #1;
    checks++; if (if_a.busy_count !== 6'd1) begin errors++; $display("FAIL rereserve_count: got %0d expected 1", if_a.busy_count); end
    @(negedge clk);
    tb_reserve_en = 1'b1; tb_reserve_reg = 5'd10;
    @(posedge clk); #1; idle(); #1;
    checks++; if (if_a.busy_count !== 6'd2) begin errors++; $display("FAIL two_busy_count: got %0d expected 2", if_a.busy_count); end
    checks++; if (if_a.read_busy !== 2'b11) begin errors++; $display("FAIL two_busy_bits: got %b expected 11", if_a.read_busy); end
    @(negedge clk);
    tb_we = 2'b11; tb_wreg = {5'd10, 5'd4}; tb_wdata = {32'hA0A0, 32'h4040};
    @(posedge clk); #1; idle(); #1;
    checks++; if (if_a.busy_count !== 6'd0) begin errors++; $display("FAIL dual_clear_count: got %0d expected 0", if_a.busy_count); end
    checks++; if (a_rd1 !== 32'hA0A0) begin errors++; $display("FAIL dual_clear_data: got %h expected %h", a_rd1, 32'hA0A0); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    tb_we = 2'b01; tb_wreg = {5'd0, 5'd5}; tb_wdata = {32'h0, 32'hDEADBEEF};
    tb_reserve_en = 1'b1; tb_reserve_reg = 5'd6;
    tb_read_reg = {5'd6, 5'd5};
    @(posedge clk); #1; idle(); #1;
    checks++; if (a_rd0 !== 32'hDEADBEEF) begin errors++; $display("FAIL pre_reset_data: got %h expected %h", a_rd0, 32'hDEADBEEF); end
    checks++; if (if_a.busy_count !== 6'd1) begin errors++; $display("FAIL pre_reset_count: got %0d expected 1", if_a.busy_count); end
    #1; rst = 1'b1; #1;
    checks++; if (a_rd0 !== 32'h0) begin errors++; $display("FAIL async_reset_data: got %h expected %h", a_rd0, 32'h0); end
    checks++; if (if_a.busy_count !== 6'd0) begin errors++; $display("FAIL async_reset_count: got %0d expected 0", if_a.busy_count); end
    checks++; if (if_a.read_busy[1] !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b expected 0", if_a.read_busy[1]); end
    // A write/reserve presented while reset is held must not land.
    tb_we = 2'b01; tb_wreg = {5'd0, 5'd5}; tb_wdata = {32'h0, 32'h11111111};
    tb_reserve_en = 1'b1; tb_reserve_reg = 5'd6;
    @(posedge clk); #1; idle(); #1;
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (a_rd0 !== 32'h0) begin errors++; $display("FAIL reset_override_data: got %h expected %h", a_rd0, 32'h0); end
    checks++; if (if_a.busy_count !== 6'd0) begin errors++; $display("FAIL reset_override_count: got %0d expected 0", if_a.busy_count); end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_conflict();
    test_zero_reg();
    test_scoreboard();
    test_collision();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
